// File: rtl/branch_target_buffer_if.sv
// Lookup, update and flush signals of the branch target buffer.
// master = fetch/resolve side, slave = the buffer itself.
interface branch_target_buffer_if #(
    parameter int PC_WIDTH = 10
);
    logic [PC_WIDTH-1:0] lkp_pc;
    logic                lkp_hit;
    logic                lkp_taken;
    logic [PC_WIDTH-1:0] lkp_target;
    logic                upd_valid;
    logic [PC_WIDTH-1:0] upd_pc;
    logic [PC_WIDTH-1:0] upd_target;
    logic                upd_taken;
    logic                flush_req;
    logic                flush_busy;

    modport master (
        output lkp_pc, upd_valid, upd_pc, upd_target, upd_taken, flush_req,
        input  lkp_hit, lkp_taken, lkp_target, flush_busy
    );

    modport slave (
        input  lkp_pc, upd_valid, upd_pc, upd_target, upd_taken, flush_req,
        output lkp_hit, lkp_taken, lkp_target, flush_busy
    );
endinterface

// File: rtl/branch_target_buffer.sv
// 2-way set-associative branch target buffer with combinational lookup and a one-set-per-cycle flush sweep.
// Optional macro BTB_DIRECTION_PREDICT_EN adds 2-bit direction counters per entry.
module branch_target_buffer #(
    parameter int PC_WIDTH    = 10,
    parameter int INDEX_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    branch_target_buffer_if.slave bus
);

    localparam int SETS      = 2 ** INDEX_WIDTH;
    localparam int TAG_WIDTH = PC_WIDTH - INDEX_WIDTH;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t                 state_reg;
    logic [INDEX_WIDTH-1:0] flush_ptr_reg;
    logic                   flush_busy_reg;
    logic [SETS-1:0]        lru_reg;

    logic [INDEX_WIDTH-1:0] lkp_idx;
    logic [INDEX_WIDTH-1:0] upd_idx;
    logic [TAG_WIDTH-1:0]   lkp_tag;
    logic [TAG_WIDTH-1:0]   upd_tag;

    logic [1:0]             lkp_way_hit;
    logic [1:0]             lkp_way_taken;
    logic [PC_WIDTH-1:0]    lkp_way_target [2];
    logic [1:0]             upd_way_hit;
    logic [1:0]             upd_way_valid;

    logic                   lkp_hit_w;
    logic                   lkp_sel;
    logic                   upd_en;
    logic                   upd_hit;
    logic                   upd_wr_en;
    logic                   upd_wr_way;
    logic                   alloc_way;

    assign lkp_idx = bus.lkp_pc[INDEX_WIDTH-1:0];
    assign lkp_tag = bus.lkp_pc[PC_WIDTH-1:INDEX_WIDTH];
    assign upd_idx = bus.upd_pc[INDEX_WIDTH-1:0];
    assign upd_tag = bus.upd_pc[PC_WIDTH-1:INDEX_WIDTH];

    // Flush FSM: flush_busy_reg mirrors the FLUSH state so it is a clean registered output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= IDLE;
            flush_ptr_reg  <= '0;
            flush_busy_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.flush_req) begin
                        state_reg      <= FLUSH;
                        flush_busy_reg <= 1'b1;
                        flush_ptr_reg  <= '0;
                    end
                end
                FLUSH: begin
                    if (&flush_ptr_reg) begin
                        state_reg      <= IDLE;
                        flush_busy_reg <= 1'b0;
                        flush_ptr_reg  <= '0;
                    end else begin
                        flush_ptr_reg <= flush_ptr_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    flush_busy_reg <= 1'b0;
                    flush_ptr_reg  <= '0;
                end
            endcase
        end
    end

    // Update decode: a hit refreshes its way; a taken miss allocates invalid way 0, way 1, then LRU.
    assign upd_en     = bus.upd_valid && !flush_busy_reg;
    assign upd_hit    = |upd_way_hit;
    assign alloc_way  = !upd_way_valid[0] ? 1'b0 :
                        !upd_way_valid[1] ? 1'b1 : lru_reg[upd_idx];
    assign upd_wr_way = upd_hit ? !upd_way_hit[0] : alloc_way;
    assign upd_wr_en  = upd_en && (upd_hit || bus.upd_taken);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lru_reg <= '0;
        end else if (flush_busy_reg) begin
            lru_reg[flush_ptr_reg] <= 1'b0;
        end else if (upd_wr_en) begin
            lru_reg[upd_idx] <= !upd_wr_way;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_way
            logic [SETS-1:0]      valid_reg;
            logic [TAG_WIDTH-1:0] tag_mem    [SETS];
            logic [PC_WIDTH-1:0]  target_mem [SETS];
            logic                 way_wr;

            assign way_wr = upd_wr_en && (upd_wr_way == 1'(gi));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    valid_reg <= '0;
                end else if (flush_busy_reg) begin
                    valid_reg[flush_ptr_reg] <= 1'b0;
                end else if (way_wr) begin
                    valid_reg[upd_idx] <= 1'b1;
                end
            end

            // Payload storage carries no reset; valid_reg alone qualifies it.
            always_ff @(posedge clk) begin
                if (way_wr) begin
                    tag_mem[upd_idx]    <= upd_tag;
                    target_mem[upd_idx] <= bus.upd_target;
                end
            end

            assign lkp_way_hit[gi]    = valid_reg[lkp_idx] && (tag_mem[lkp_idx] == lkp_tag);
            assign lkp_way_target[gi] = target_mem[lkp_idx];
            assign upd_way_hit[gi]    = valid_reg[upd_idx] && (tag_mem[upd_idx] == upd_tag);
            assign upd_way_valid[gi]  = valid_reg[upd_idx];

`ifdef BTB_DIRECTION_PREDICT_EN
            logic [1:0] ctr_mem [SETS];
            logic [1:0] ctr_cur;
            logic [1:0] ctr_next;

            assign ctr_cur = ctr_mem[upd_idx];

            // Saturating step on a hit; fresh allocations start weakly taken.
            always_comb begin
                ctr_next = 2'b10;
                if (upd_hit) begin
                    if (bus.upd_taken) begin
                        ctr_next = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'd1;
                    end else begin
                        ctr_next = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'd1;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (way_wr) begin
                    ctr_mem[upd_idx] <= ctr_next;
                end
            end

            assign lkp_way_taken[gi] = ctr_mem[lkp_idx][1];
`else
            assign lkp_way_taken[gi] = 1'b1;
`endif
        end
    endgenerate

    // A set holding the tag in both ways is treated as a miss; the sweep blanks all hits.
    assign lkp_hit_w = (lkp_way_hit[0] ^ lkp_way_hit[1]) && !flush_busy_reg;
    assign lkp_sel   = lkp_way_hit[1];

    assign bus.lkp_hit    = lkp_hit_w;
    assign bus.lkp_taken  = lkp_hit_w && lkp_way_taken[lkp_sel];
    assign bus.lkp_target = lkp_hit_w ? lkp_way_target[lkp_sel] : '0;
    assign bus.flush_busy = flush_busy_reg;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Directed self-checking bench for branch_target_buffer: reset, allocation/LRU, counters or target rewrite, flush.
module tb_branch_target_buffer;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   passed = 0;

    branch_target_buffer_if #(.PC_WIDTH(10)) bus ();

    branch_target_buffer #(.PC_WIDTH(10), .INDEX_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Drive one update across a single rising edge, then release the strobe.
    task automatic do_update(input logic [9:0] pc, input logic [9:0] tgt, input logic tkn);
        @(negedge clk);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = pc;
        bus.upd_target = tgt;
        bus.upd_taken  = tkn;
        @(negedge clk);
        bus.upd_valid  = 1'b0;
    endtask

    task automatic look(input logic [9:0] pc);
        bus.lkp_pc = pc;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        int bad;
        bus.lkp_pc = '0; bus.upd_valid = 1'b0; bus.upd_pc = '0;
        bus.upd_target = '0; bus.upd_taken = 1'b0; bus.flush_req = 1'b0;
        #2;
        checks++;
        if (bus.flush_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.flush_busy);
        else passed++;
        checks++;
        if (bus.lkp_hit !== 1'b0 || bus.lkp_taken !== 1'b0)
            $display("FAIL reset_hit: got hit=%b taken=%b want 0/0", bus.lkp_hit, bus.lkp_taken);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        bad = 0;
        for (int a = 0; a < 1024; a++) begin
            look(10'(a));
            if (bus.lkp_hit !== 1'b0 || bus.lkp_target !== 10'h000 || bus.lkp_taken !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL reset_sweep: got %0d hitting addresses want 0", bad);
        else passed++;
        $display("test_reset done");
    endtask

    task automatic test_basic();
        do_update(10'h015, 10'h2A0, 1'b1);
        look(10'h015);
        checks++;
        if (bus.lkp_hit !== 1'b1 || bus.lkp_target !== 10'h2A0 || bus.lkp_taken !== 1'b1)
            $display("FAIL basic_hit: got hit=%b tgt=%h taken=%b want 1/2a0/1",
                     bus.lkp_hit, bus.lkp_target, bus.lkp_taken);
        else passed++;
        look(10'h025);
        checks++;
        if (bus.lkp_hit !== 1'b0 || bus.lkp_target !== 10'h000 || bus.lkp_taken !== 1'b0)
            $display("FAIL basic_miss: got hit=%b tgt=%h taken=%b want 0/000/0",
                     bus.lkp_hit, bus.lkp_target, bus.lkp_taken);
        else passed++;
        $display("test_basic done");
    endtask

    task automatic test_lru();
        // Set 5: way0=0x015 (LRU->1); 0x025 fills way1 (LRU->0); 0x035 evicts way0.
        do_update(10'h025, 10'h111, 1'b1);
        do_update(10'h035, 10'h222, 1'b1);
        look(10'h015);
        checks++;
        if (bus.lkp_hit !== 1'b0) $display("FAIL lru_evict: got hit=%b want 0", bus.lkp_hit);
        else passed++;
        look(10'h025);
        checks++;
        if (bus.lkp_hit !== 1'b1 || bus.lkp_target !== 10'h111)
            $display("FAIL lru_keep25: got hit=%b tgt=%h want 1/111", bus.lkp_hit, bus.lkp_target);
        else passed++;
        look(10'h035);
        checks++;
        if (bus.lkp_hit !== 1'b1 || bus.lkp_target !== 10'h222)
            $display("FAIL lru_keep35: got hit=%b tgt=%h want 1/222", bus.lkp_hit, bus.lkp_target);
        else passed++;
        // Hit on way1 (0x025) retargets it and points LRU at way0, so 0x045 displaces 0x035.
        do_update(10'h025, 10'h333, 1'b1);
        do_update(10'h045, 10'h044, 1'b1);
        look(10'h035);
        checks++;
        if (bus.lkp_hit !== 1'b0) $display("FAIL lru_hit_refresh: got hit=%b want 0", bus.lkp_hit);
        else passed++;
        look(10'h025);
        checks++;
        if (bus.lkp_hit !== 1'b1 || bus.lkp_target !== 10'h333)
            $display("FAIL lru_retarget: got hit=%b tgt=%h want 1/333", bus.lkp_hit, bus.lkp_target);
        else passed++;
        // Not-taken miss leaves the set alone.
        do_update(10'h055, 10'h0AA, 1'b0);
        look(10'h055);
        checks++;
        if (bus.lkp_hit !== 1'b0) $display("FAIL nt_miss_alloc: got hit=%b want 0", bus.lkp_hit);
        else passed++;
        look(10'h045);
        checks++;
        if (bus.lkp_hit !== 1'b1 || bus.lkp_target !== 10'h044)
            $display("FAIL nt_miss_keep: got hit=%b tgt=%h want 1/044", bus.lkp_hit, bus.lkp_target);
        else passed++;
        $display("test_lru done");
    endtask

`ifdef BTB_DIRECTION_PREDICT_EN
    task automatic test_counter();
        apply_reset();
        do_update(10'h015, 10'h2A0, 1'b1);   // ctr=2
        do_update(10'h015, 10'h2A0, 1'b0);   // 1
        do_update(10'h015, 10'h2A0, 1'b0);   // 0
        look(10'h015);
        checks++;
        if (bus.lkp_hit !== 1'b1 || bus.lkp_taken !== 1'b0)
            $display("FAIL ctr_nt: got hit=%b taken=%b want 1/0", bus.lkp_hit, bus.lkp_taken);
        else passed++;
        do_update(10'h015, 10'h2A0, 1'b1);   // 1
        do_update(10'h015, 10'h2A0, 1'b1);   // 2
        look(10'h015);
        checks++;
        if (bus.lkp_taken !== 1'b1) $display("FAIL ctr_t: got taken=%b want 1", bus.lkp_taken);
        else passed++;
        for (int i = 0; i < 5; i++) do_update(10'h015, 10'h2A0, 1'b1);   // saturate at 3
        do_update(10'h015, 10'h2A0, 1'b0);   // 2
        look(10'h015);
        checks++;
        if (bus.lkp_taken !== 1'b1) $display("FAIL ctr_sat_a: got taken=%b want 1", bus.lkp_taken);
        else passed++;
        do_update(10'h015, 10'h2A0, 1'b0);   // 1
        look(10'h015);
        checks++;
        if (bus.lkp_taken !== 1'b0) $display("FAIL ctr_sat_b: got taken=%b want 0", bus.lkp_taken);
        else passed++;
        $display("test_counter done");
    endtask
`else
    task automatic test_target_rewrite();
        apply_reset();
        do_update(10'h015, 10'h2A0, 1'b1);
        do_update(10'h015, 10'h123, 1'b0);
        look(10'h015);
        checks++;
        if (bus.lkp_hit !== 1'b1 || bus.lkp_target !== 10'h123 || bus.lkp_taken !== 1'b1)
            $display("FAIL nt_rewrite: got hit=%b tgt=%h taken=%b want 1/123/1",
                     bus.lkp_hit, bus.lkp_target, bus.lkp_taken);
        else passed++;
        $display("test_target_rewrite done");
    endtask
`endif

    task automatic test_flush();
        int n;
        int bad;
        logic [9:0] addrs [5];
        addrs = '{10'h000, 10'h010, 10'h00F, 10'h3FF, 10'h123};
        apply_reset();
        do_update(10'h000, 10'h001, 1'b1);
        do_update(10'h010, 10'h002, 1'b1);
        do_update(10'h00F, 10'h003, 1'b1);
        do_update(10'h3FF, 10'h004, 1'b1);
        look(10'h3FF);
        checks++;
        if (bus.lkp_hit !== 1'b1 || bus.lkp_target !== 10'h004)
            $display("FAIL flush_prefill: got hit=%b tgt=%h want 1/004", bus.lkp_hit, bus.lkp_target);
        else passed++;
        @(negedge clk);
        bus.flush_req = 1'b1;
        @(negedge clk);
        bus.flush_req = 1'b0;
        look(10'h00F);
        checks++;
        if (bus.lkp_hit !== 1'b0) $display("FAIL flush_gate: got hit=%b want 0", bus.lkp_hit);
        else passed++;
        n = 0;
        while (bus.flush_busy === 1'b1 && n < 100) begin
            n++;
            // Write set 3 after the sweep has passed it; a re-flush request must also be ignored.
            bus.upd_valid  = (n == 10);
            bus.upd_pc     = 10'h123;
            bus.upd_target = 10'h0EE;
            bus.upd_taken  = 1'b1;
            bus.flush_req  = (n == 12);
            @(negedge clk);
        end
        bus.upd_valid = 1'b0;
        bus.flush_req = 1'b0;
        checks++;
        if (n != 16) $display("FAIL flush_len: got %0d busy cycles want 16", n);
        else passed++;
        @(negedge clk);
        checks++;
        if (bus.flush_busy !== 1'b0) $display("FAIL flush_rereq: got busy=%b want 0", bus.flush_busy);
        else passed++;
        bad = 0;
        foreach (addrs[i]) begin
            look(addrs[i]);
            if (bus.lkp_hit !== 1'b0 || bus.lkp_target !== 10'h000) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL flush_clear: got %0d hitting addresses want 0", bad);
        else passed++;
        $display("test_flush done");
    endtask

    task automatic test_same_cycle();
        @(negedge clk);
        bus.lkp_pc     = 10'h033;
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 10'h033;
        bus.upd_target = 10'h0C3;
        bus.upd_taken  = 1'b1;
        #1;
        checks++;
        if (bus.lkp_hit !== 1'b0) $display("FAIL same_cycle_pre: got hit=%b want 0", bus.lkp_hit);
        else passed++;
        @(negedge clk);
        bus.upd_valid = 1'b0;
        #1;
        checks++;
        if (bus.lkp_hit !== 1'b1 || bus.lkp_target !== 10'h0C3)
            $display("FAIL same_cycle_post: got hit=%b tgt=%h want 1/0c3", bus.lkp_hit, bus.lkp_target);
        else passed++;
        $display("test_same_cycle done");
    endtask

    task automatic test_update_with_flush();
        int n;
        @(negedge clk);
        bus.upd_valid  = 1'b1;
        bus.upd_pc     = 10'h044;
        bus.upd_target = 10'h1BB;
        bus.upd_taken  = 1'b1;
        bus.flush_req  = 1'b1;
        @(negedge clk);
        bus.upd_valid = 1'b0;
        bus.flush_req = 1'b0;
        checks++;
        if (bus.flush_busy !== 1'b1) $display("FAIL upd_flush_busy: got %b want 1", bus.flush_busy);
        else passed++;
        n = 0;
        while (bus.flush_busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        look(10'h044);
        checks++;
        if (n != 16 || bus.lkp_hit !== 1'b0)
            $display("FAIL upd_flush_clear: got busy=%0d hit=%b want 16/0", n, bus.lkp_hit);
        else passed++;
        $display("test_update_with_flush done");
    endtask

    task automatic test_reset_mid_flush();
        do_update(10'h077, 10'h0F0, 1'b1);
        @(negedge clk);
        bus.flush_req = 1'b1;
        @(negedge clk);
        bus.flush_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        checks++;
        if (bus.flush_busy !== 1'b0) $display("FAIL rst_mid_flush: got busy=%b want 0", bus.flush_busy);
        else passed++;
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        look(10'h077);
        checks++;
        if (bus.flush_busy !== 1'b0 || bus.lkp_hit !== 1'b0)
            $display("FAIL rst_idle: got busy=%b hit=%b want 0/0", bus.flush_busy, bus.lkp_hit);
        else passed++;
        do_update(10'h077, 10'h0F1, 1'b1);
        look(10'h077);
        checks++;
        if (bus.lkp_hit !== 1'b1 || bus.lkp_target !== 10'h0F1)
            $display("FAIL rst_recover: got hit=%b tgt=%h want 1/0f1", bus.lkp_hit, bus.lkp_target);
        else passed++;
        $display("test_reset_mid_flush done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lru();
`ifdef BTB_DIRECTION_PREDICT_EN
        test_counter();
`else
        test_target_rewrite();
`endif
        test_flush();
        test_same_cycle();
        test_update_with_flush();
        test_reset_mid_flush();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
